// File: rtl/freq_meter.sv
// freq_meter: gated frequency counter. Counts rising edges of an asynchronous
// square wave over a programmable window of clk cycles and hands each result
// out on a valid/ready interface. Edges arriving while a result waits for
// acceptance are dead time and are not counted.
module freq_meter #(
  parameter int SYNC_STAGES = 2,
  parameter int GATE_W      = 32,
  parameter int CNT_W       = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              sig_in,
  output logic [CNT_W-1:0]  freq_count,
  output logic              freq_valid,
  input  logic              freq_ready,
  output logic              overflow,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, GATE, REPORT} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic             ovf;
  } result_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_pulse;
  logic [GATE_W-1:0]      timer_q;
  logic [CNT_W-1:0]       cnt_q, cnt_nxt;
  logic                   sticky_q, sticky_nxt;
  logic                   cnt_sat;
  result_t                res_q;
  logic                   load_win, cnt_en, finish;

  // Synchronizer chain plus one delayed copy for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Saturating count including this cycle's edge; the last window cycle
  // publishes these so an edge on that cycle still lands in the result.
  assign cnt_sat    = &cnt_q;
  assign cnt_nxt    = (edge_pulse && !cnt_sat) ? cnt_q + CNT_W'(1) : cnt_q;
  assign sticky_nxt = sticky_q | (edge_pulse & cnt_sat);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath controls. In REPORT valid is always high, so
  // freq_ready alone completes the handshake.
  always_comb begin
    state_d  = state_q;
    load_win = 1'b0;
    cnt_en   = 1'b0;
    finish   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && gate_cycles != '0) begin
          load_win = 1'b1;
          state_d  = GATE;
        end
      end
      GATE: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          cnt_en = 1'b1;
          if (timer_q == '0) begin
            finish  = 1'b1;
            state_d = REPORT;
          end
        end
      end
      REPORT: begin
        if (freq_ready) begin
          state_d = IDLE;
          if (enable && gate_cycles != '0) begin
            load_win = 1'b1;
            state_d  = GATE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Window timer, edge counter and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q  <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else if (load_win) begin
      timer_q  <= gate_cycles - GATE_W'(1);
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else if (cnt_en) begin
      timer_q  <= timer_q - GATE_W'(1);
      cnt_q    <= cnt_nxt;
      sticky_q <= sticky_nxt;
    end
  end

  // Result register: loaded once per completed window, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      res_q <= '0;
    else if (finish) res_q <= '{count: cnt_nxt, ovf: sticky_nxt};
  end

  assign freq_count = res_q.count;
  assign overflow   = res_q.ovf;
  assign freq_valid = (state_q == REPORT);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed bench with a result scoreboard. Expected results
// are queued when a window is launched and compared at each handshake.
module tb_freq_meter;
  localparam int SYNC_STAGES = 2;
  localparam int GATE_W      = 32;
  localparam int CNT_W       = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [GATE_W-1:0] gate_cycles = '0;
  logic              sig_in = 1'b0;
  logic [CNT_W-1:0]  freq_count;
  logic              freq_valid;
  logic              freq_ready = 1'b0;
  logic              overflow;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int n_results = 0;

  // sig_in source: 0 low, 1 period 10 (5/5), 2 period 2, 3 follow man_sig
  int   mode = 0;
  int   last_mode = -1;
  int   ph = 0;
  logic man_sig = 1'b0;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  freq_meter #(.SYNC_STAGES(SYNC_STAGES), .GATE_W(GATE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .gate_cycles(gate_cycles),
    .sig_in(sig_in), .freq_count(freq_count), .freq_valid(freq_valid),
    .freq_ready(freq_ready), .overflow(overflow), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_results(input int target, input int budget, input string tag);
    int n = 0;
    while (n_results < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, n_results, target);
  endtask

  // Stimulus generator, phase restarts whenever the mode changes.
  always @(posedge clk) begin
    #2;
    if (mode != last_mode) begin
      ph = 0;
      last_mode = mode;
    end
    case (mode)
      1:       sig_in = (ph % 10) < 5;
      2:       sig_in = (ph % 2) == 0;
      3:       sig_in = man_sig;
      default: sig_in = 1'b0;
    endcase
    ph++;
  end

  // Scoreboard: every handshake pops one expected result.
  always @(negedge clk) begin
    if (rst_n && freq_valid && freq_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("result_count", freq_count, mon_e.cnt);
        check("result_ovf", overflow, mon_e.ovf);
      end
      n_results++;
    end
  end

  initial begin
    int bad;
    int n;
    int base;

    // 1. reset hold with activity on the inputs
    enable = 1'b1; gate_cycles = 100; mode = 1; freq_ready = 1'b1;
    repeat (10) step();
    check("rst_count", freq_count, 0);
    check("rst_valid", freq_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    mode = 0;
    repeat (5) step();
    rst_n = 1'b1; mode = 1;
    repeat (50) step();
    check("mid_busy_before", busy, 1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", freq_valid, 0);
    check("mid_rst_count", freq_count, 0);
    mode = 0;
    repeat (5) step();

    // 1/2. full window after release, then steady repeated results
    rst_n = 1'b1; mode = 1;
    repeat (3) sb_q.push_back('{cnt: 4'd10, ovf: 1'b0});
    bad = 0;
    for (int i = 0; i < 101; i++) begin
      @(negedge clk);
      if (freq_valid) bad++;
    end
    check("no_early_valid", bad, 0);
    @(negedge clk);
    check("first_valid", freq_valid, 1);
    wait_results(3, 400, "basic_results");
    step(); enable = 1'b0;
    repeat (5) step();
    check("basic_idle", busy, 0);

    // 3. saturation, then a quiet window
    base = n_results;
    gate_cycles = 40;
    sb_q.push_back('{cnt: 4'd15, ovf: 1'b1});
    sb_q.push_back('{cnt: 4'd0, ovf: 1'b0});
    mode = 2; enable = 1'b1;
    repeat (36) step();
    mode = 0;
    wait_results(base + 2, 200, "sat_results");
    step(); enable = 1'b0;
    repeat (5) step();
    check("sat_idle", busy, 0);

    // 4. backpressure with fast edges during the stall
    base = n_results;
    freq_ready = 1'b0; gate_cycles = 100; mode = 1; enable = 1'b1;
    sb_q.push_back('{cnt: 4'd10, ovf: 1'b0});
    sb_q.push_back('{cnt: 4'd0, ovf: 1'b0});
    n = 0;
    while (!freq_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_rise", freq_valid, 1);
    mode = 2;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 40) mode = 0;
      check("bp_valid_held", freq_valid, 1);
      check("bp_count_held", freq_count, 10);
      check("bp_ovf_held", overflow, 0);
    end
    step(); freq_ready = 1'b1;
    @(posedge clk);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0) check("bp_busy_after_hs", busy, 1);
      if (freq_valid) bad++;
    end
    check("bp_window_len", bad, 0);
    @(negedge clk);
    check("bp_next_valid", freq_valid, 1);
    wait_results(base + 2, 10, "bp_results");
    step(); enable = 1'b0;
    repeat (5) step();

    // 5. abort at window cycle 30, then zero gate
    base = n_results;
    gate_cycles = 100; mode = 1; enable = 1'b1;
    repeat (30) step();
    check("abort_busy_before", busy, 1);
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_valid", freq_valid, 0);
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (freq_valid) bad++;
    end
    check("abort_no_result", bad, 0);
    gate_cycles = 0; enable = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy || freq_valid) bad++;
    end
    check("zero_gate_idle", bad, 0);
    check("abort_results", n_results, base);
    step(); enable = 1'b0;

    // 6. edge on the last window cycle, then edge on the REPORT cycle
    mode = 3; man_sig = 1'b0; gate_cycles = 20;
    repeat (5) step();
    base = n_results;
    sb_q.push_back('{cnt: 4'd1, ovf: 1'b0});
    enable = 1'b1;
    repeat (18) step();
    man_sig = 1'b1;
    repeat (3) step();
    enable = 1'b0;
    wait_results(base + 1, 20, "edge_last_result");
    repeat (3) step();
    check("edge_last_idle", busy, 0);
    man_sig = 1'b0;
    repeat (5) step();
    base = n_results;
    sb_q.push_back('{cnt: 4'd0, ovf: 1'b0});
    sb_q.push_back('{cnt: 4'd0, ovf: 1'b0});
    enable = 1'b1;
    repeat (19) step();
    man_sig = 1'b1;
    wait_results(base + 2, 80, "edge_dead_results");
    step(); enable = 1'b0;
    repeat (5) step();
    check("final_idle", busy, 0);
    check("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
